// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-size encodings, FSM states
// and the byte-lane index width helper.
package wb_pkg;

    localparam logic [1:0] LS_FULL = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_SPLIT = 1'b1
    } wb_state_e;

    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Sub-word load alignment: picks the addressed byte or halfword out of the raw
// memory word and sign- or zero-extends it to the datapath width.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int LB = lane_bits(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [LB-1:0]         lane_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_i,
    output logic [DATA_WIDTH-1:0] value_o
);

    logic [LB-1:0] lane_h;
    logic [7:0]    byte_w;
    logic [15:0]   half_w;

    // Misaligned halfwords fall back to the aligned half containing the lane.
    assign lane_h = {lane_i[LB-1:1], 1'b0};
    assign byte_w = data_i[{lane_i, 3'b000} +: 8];
    assign half_w = data_i[{lane_h, 3'b000} +: 16];

    always_comb begin
        value_o = data_i;
        case (size_i)
            LS_HALF: value_o = {{(DATA_WIDTH-16){sign_i & half_w[15]}}, half_w};
            LS_BYTE: value_o = {{(DATA_WIDTH-8){sign_i & byte_w[7]}}, byte_w};
            default: value_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_multi.sv
// Writeback stage: registers the result, aligns sub-word loads, and issues the
// base-register update either split over two cycles (one port) or in parallel.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   WB_RUN   | accepting; outputs carry the last accepted instruction
//   WB_SPLIT | base write on port 0, held primary write goes out next cycle
module wb_stage_multi
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DUAL_PORT      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [DATA_WIDTH-1:0]     i_Pc,
    input  logic                      i_Sig_Write_Back_Enable,
    input  logic                      i_Sig_Memory_Read_Enable,
    input  logic [1:0]                i_Load_Size,
    input  logic                      i_Load_Signed,
    input  logic [DATA_WIDTH-1:0]     i_ALU_Result,
    input  logic [DATA_WIDTH-1:0]     i_Data_Memory,
    input  logic [REG_ADDR_WIDTH-1:0] i_Destination,
    input  logic                      i_Sig_Base_Write_Enable,
    input  logic [REG_ADDR_WIDTH-1:0] i_Base_Destination,
    input  logic [DATA_WIDTH-1:0]     i_Base_Value,
    output logic                      o_Valid,
    output logic [DATA_WIDTH-1:0]     o_Pc,
    output logic                      o_Sig_Write_Back_Enable,
    output logic [DATA_WIDTH-1:0]     o_Write_Back_Value,
    output logic [REG_ADDR_WIDTH-1:0] o_Destination,
    output logic                      o_Sig_Write_Back_Enable_1,
    output logic [DATA_WIDTH-1:0]     o_Write_Back_Value_1,
    output logic [REG_ADDR_WIDTH-1:0] o_Destination_1
);

    localparam int LANE_BITS  = lane_bits(DATA_WIDTH);
    localparam bit SPLIT_MODE = (DUAL_PORT == 0);

    wb_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     hold_val_q, hold_val_d;
    logic [REG_ADDR_WIDTH-1:0] hold_dst_q, hold_dst_d;
    logic [DATA_WIDTH-1:0]     hold_pc_q, hold_pc_d;

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic                      we0_q, we0_d;
    logic [DATA_WIDTH-1:0]     val0_q, val0_d;
    logic [REG_ADDR_WIDTH-1:0] dst0_q, dst0_d;
    logic                      we1_q, we1_d;
    logic [DATA_WIDTH-1:0]     val1_q, val1_d;
    logic [REG_ADDR_WIDTH-1:0] dst1_q, dst1_d;

    logic [DATA_WIDTH-1:0]     load_val;
    logic [DATA_WIDTH-1:0]     primary_val;
    logic                      accept;

    wb_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .data_i  (i_Data_Memory),
        .lane_i  (i_ALU_Result[LANE_BITS-1:0]),
        .size_i  (i_Load_Size),
        .sign_i  (i_Load_Signed),
        .value_o (load_val)
    );

    assign primary_val = i_Sig_Memory_Read_Enable ? load_val : i_ALU_Result;
    assign o_Ready     = reset && (state_q == WB_RUN);
    assign accept      = i_Valid && o_Ready;

    always_comb begin
        state_d    = state_q;
        hold_val_d = hold_val_q;
        hold_dst_d = hold_dst_q;
        hold_pc_d  = hold_pc_q;
        valid_d    = 1'b0;
        pc_d       = pc_q;
        we0_d      = 1'b0;
        val0_d     = val0_q;
        dst0_d     = dst0_q;
        we1_d      = 1'b0;
        val1_d     = val1_q;
        dst1_d     = dst1_q;

        if (state_q == WB_SPLIT) begin
            valid_d = 1'b1;
            pc_d    = hold_pc_q;
            we0_d   = 1'b1;
            val0_d  = hold_val_q;
            dst0_d  = hold_dst_q;
            state_d = WB_RUN;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = i_Pc;
            if (!SPLIT_MODE) begin
                we0_d  = i_Sig_Write_Back_Enable;
                val0_d = primary_val;
                dst0_d = i_Destination;
                // Same register on both ports: only the primary (load) write lands.
                we1_d  = i_Sig_Base_Write_Enable &&
                         !(i_Sig_Write_Back_Enable && (i_Destination == i_Base_Destination));
                val1_d = i_Base_Value;
                dst1_d = i_Base_Destination;
            end else if (i_Sig_Write_Back_Enable && i_Sig_Base_Write_Enable) begin
                we0_d      = 1'b1;
                val0_d     = i_Base_Value;
                dst0_d     = i_Base_Destination;
                hold_val_d = primary_val;
                hold_dst_d = i_Destination;
                hold_pc_d  = i_Pc;
                state_d    = WB_SPLIT;
            end else if (i_Sig_Base_Write_Enable) begin
                we0_d  = 1'b1;
                val0_d = i_Base_Value;
                dst0_d = i_Base_Destination;
            end else begin
                we0_d  = i_Sig_Write_Back_Enable;
                val0_d = primary_val;
                dst0_d = i_Destination;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WB_RUN;
            hold_val_q <= '0;
            hold_dst_q <= '0;
            hold_pc_q  <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            we0_q      <= 1'b0;
            val0_q     <= '0;
            dst0_q     <= '0;
            we1_q      <= 1'b0;
            val1_q     <= '0;
            dst1_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_val_q <= hold_val_d;
            hold_dst_q <= hold_dst_d;
            hold_pc_q  <= hold_pc_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            we0_q      <= we0_d;
            val0_q     <= val0_d;
            dst0_q     <= dst0_d;
            we1_q      <= we1_d;
            val1_q     <= val1_d;
            dst1_q     <= dst1_d;
        end
    end

    assign o_Valid                   = valid_q;
    assign o_Pc                      = pc_q;
    assign o_Sig_Write_Back_Enable   = we0_q;
    assign o_Write_Back_Value        = val0_q;
    assign o_Destination             = dst0_q;
    assign o_Sig_Write_Back_Enable_1 = we1_q;
    assign o_Write_Back_Value_1      = val1_q;
    assign o_Destination_1           = dst1_q;

endmodule

// File: doc/wb_stage_multi.md
# wb_stage_multi

Parametrised writeback stage for the ARM pipeline, between the MEM/WB pipeline register and the register file write ports. It registers the writeback result and aligns and extends sub-word loads (byte and halfword, signed or unsigned). It also handles a second writeback per instruction: the base-register update of pre-indexed or post-indexed loads and stores. With one register-file write port, the two writes are serialised over two cycles and the stage back-pressures MEM; with two ports, both are issued in the same cycle.

## Interface
- DATA_WIDTH, 32: datapath width; power of two, at least 32.
- REG_ADDR_WIDTH, 4: register index width.
- DUAL_PORT, 0: 0 = one write port (split writes); 1 = two write ports.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_Valid  in  1  MEM stage presents an instruction.
- o_Ready  out  1  stage accepts; transfer when i_Valid && o_Ready.
- i_Pc  in  DATA_WIDTH  instruction PC.
- i_Sig_Write_Back_Enable  in  1  primary write requested.
- i_Sig_Memory_Read_Enable  in  1  primary value comes from memory, not ALU.
- i_Load_Size  in  2  00 full width, 01 half, 10 byte, 11 treated as 00.
- i_Load_Signed  in  1  sign-extend sub-word load.
- i_ALU_Result  in  DATA_WIDTH  ALU result; its low bits also give the byte lane of a load.
- i_Data_Memory  in  DATA_WIDTH  raw memory read word.
- i_Destination  in  REG_ADDR_WIDTH  primary destination register.
- i_Sig_Base_Write_Enable  in  1  base update requested.
- i_Base_Destination  in  REG_ADDR_WIDTH  base register.
- i_Base_Value  in  DATA_WIDTH  updated base address.
- o_Valid  out  1  outputs carry a writeback this cycle.
- o_Pc  out  DATA_WIDTH  PC of the instruction being written back.
- o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination  out  1/DATA_WIDTH/REG_ADDR_WIDTH  port 0.
- o_Sig_Write_Back_Enable_1, o_Write_Back_Value_1, o_Destination_1  out  1/DATA_WIDTH/REG_ADDR_WIDTH  port 1; constant 0 when DUAL_PORT=0.

## Operation
- Lane select: LANE_BITS = log2(DATA_WIDTH/8).
  - Byte: lane = i_ALU_Result[LANE_BITS-1:0].
  - Half: uses the same lane index with bit 0 forced to 0 (misaligned halfwords read the aligned half).
  - Full width: i_Data_Memory passes through unmodified.
  - The selected field is sign-extended if i_Load_Signed, otherwise zero-extended.
- Primary value = aligned load if i_Sig_Memory_Read_Enable, else i_ALU_Result. i_Load_Size is ignored for ALU results.
- FSM (DUAL_PORT=0), states RUN and SPLIT:
  - RUN, accepted instruction with both enables set: next cycle port 0 carries the base write, state goes to SPLIT, and the primary value, destination and PC are captured into a hold register.
  - SPLIT: o_Ready=0. Next cycle port 0 carries the held primary write with the same o_Pc, then state returns to RUN.
  - Ordering rule: base first, load second, so the load wins when the two destinations are equal.
  - Any other accepted instruction: one output cycle, state stays RUN.
- DUAL_PORT=1: no SPLIT state and o_Ready=1 outside reset. Primary goes on port 0, base on port 1. If the destinations are equal, o_Sig_Write_Back_Enable_1 is forced to 0.
- Cycle with no transfer: o_Valid=0 and all write enables 0. o_Pc and value/destination outputs hold their last values.
- o_Valid=1 for any accepted instruction, including one with both enables 0 (an instruction that retires without writing).

## Timing
- Latency: 1 cycle from transfer to outputs. A split instruction occupies 2 output cycles; throughput is then 1 instruction per 2 cycles.
- o_Ready is combinational from state: 1 in RUN, 0 in SPLIT, 0 while reset=0.
- Reset (reset=0 sampled at an edge): state=RUN, hold register cleared, every output 0. A reset during SPLIT discards the pending primary write.
- i_Valid in SPLIT is ignored. MEM must hold its inputs stable until o_Ready=1.
- Back-to-back split instructions: the second is accepted in the cycle the first's primary write appears. No bubble beyond the SPLIT cycle.

## Structure
- Package wb_pkg:
  - load-size constants LS_FULL, LS_HALF, LS_BYTE;
  - FSM state enum {WB_RUN, WB_SPLIT};
  - LANE_BITS function.
- Sub-module wb_load_align: combinational lane select plus extension. Parameter DATA_WIDTH; inputs data, lane, size, signed; output value.
- Top level: handshake, FSM, hold register, output registers.

## Test plan
- ALU write: i_ALU_Result=32'hABCD1234, dest 1, MEM_R=0 -> next cycle o_Write_Back_Value=32'hABCD1234, dest 1, o_Valid=1, o_Ready stays 1.
- Signed byte load: data 32'h55667788, lane 3 -> 32'h00000055. Lane 0, signed -> 32'hFFFFFF88. Unsigned half, lane 2 -> 32'h00005566.
- Split (DUAL_PORT=0): load to r2 with base r3=32'h1004 -> cycle 1 writes r3=32'h1004, o_Ready=0; cycle 2 writes r2 with the load data at the same o_Pc; then o_Ready=1.
- Dual port: same stimulus -> both writes in one cycle. With dest=base=r5, only the port-0 load write is enabled.
- Reset mid-SPLIT: reset=0 in the SPLIT cycle -> all outputs 0, no primary write ever issued, o_Ready=1 the cycle after reset releases.
- No write: i_Valid=1 with both enables 0 -> o_Valid=1, both write enables 0. i_Valid=0 -> o_Valid=0.
